// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one unsigned WIDTH x WIDTH multiplier among NUM_REQ requesters.
// Define MULT_RR_STATS_EN to add the op_count / stall_cycles statistics outputs.
module mult_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*WIDTH-1:0]       rsp_p,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
`ifdef MULT_RR_STATS_EN
  ,
  output logic [15:0]              op_count,
  output logic [15:0]              stall_cycles
`endif
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]     rsp_p_q, rsp_p_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id, idx;
  logic [WIDTH-1:0]  a_sel, b_sel;

  // Search starts just after the last winner so every waiting requester is reached within NUM_REQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d      = a_sel;
          b_d      = b_sel;
          id_d     = grant_id;
          rr_ptr_d = grant_id;
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_p_d     = PW'(a_q) * PW'(b_q);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

`ifdef MULT_RR_STATS_EN
  logic [15:0] op_count_q, stall_q;

  // op_count wraps naturally; stall_cycles pins at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q <= '0;
      stall_q    <= '0;
    end else if (state_q == RESP) begin
      if (rsp_ready) op_count_q <= op_count_q + 16'd1;
      else if (stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign op_count     = op_count_q;
  assign stall_cycles = stall_q;
`endif

endmodule
